// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive monitor.
// Defining UART_RX_PARITY_EN adds the PARITY state used for 8O1 framing.
package uart_rx_pkg;

  localparam int OversampleRate = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    int den;
    den = baud * OversampleRate;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous byte FIFO; a pop on a full FIFO frees
// the slot for a push in the same cycle.
module uart_rx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                   soc_clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr_reg;
  logic [AddrW-1:0] rd_ptr_reg;
  logic [AddrW:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AddrW + 1)'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge soc_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AddrW'(1);
      end
      count_reg <= count_reg + {{AddrW{1'b0}}, do_push} - {{AddrW{1'b0}}, do_pop};
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver on the SoC TX line: 16x oversampled 8N1 deserialiser feeding a byte FIFO.
// Defining UART_RX_PARITY_EN switches to 8O1 and adds parity_err_o.
module uart_rx_monitor
  import uart_rx_pkg::*;
#(
  parameter int ClkFreqHz = 20000000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 8
) (
  input  logic                       soc_clk,
  input  logic                       rst_n,
  input  logic                       rx_i,
  output logic [7:0]                 rx_data_o,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  input  logic                       clear_i,
  output logic                       frame_err_o,
  output logic                       overflow_o,
`ifdef UART_RX_PARITY_EN
  output logic                       parity_err_o,
`endif
  output logic [$clog2(FifoDepth):0] fifo_count_o
);

  localparam int Div  = calc_div(ClkFreqHz, BaudRate);
  localparam int DivW = (Div > 1) ? $clog2(Div) : 1;

  rx_state_e   state_reg, state_next;
  logic [1:0]  sync_reg;
  logic        rx_sync;
  logic        rx_prev_reg;
  logic        fell;
  logic [DivW-1:0] tick_cnt_reg;
  logic        tick;
  logic        restart;
  logic [3:0]  sub_cnt_reg, sub_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [1:0]  samples_reg, samples_next;
  logic        vote_reg, vote_next;
  logic        vote_now;
  logic        push;
  logic        frame_evt;
  logic        overflow_evt;
  logic        frame_err_reg;
  logic        overflow_reg;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_reg, par_bad_next;
  logic        parity_evt;
  logic        parity_err_reg;
`endif

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx_i};
      rx_prev_reg <= sync_reg[1];
    end
  end

  assign rx_sync = sync_reg[1];
  assign fell    = rx_prev_reg && !rx_sync;

  // Tick fires while the counter is 0, so tick 0 lands right after a restart.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (restart || tick_cnt_reg == DivW'(Div - 1)) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + DivW'(1);
    end
  end

  assign tick = (tick_cnt_reg == '0);

  // Majority of the tick-7/8 samples and the live tick-9 sample.
  assign vote_now = (samples_reg[0] & samples_reg[1]) |
                    (samples_reg[0] & rx_sync) |
                    (samples_reg[1] & rx_sync);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sub_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      samples_reg <= 2'b11;
      vote_reg    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      sub_cnt_reg <= sub_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      samples_reg <= samples_next;
      vote_reg    <= vote_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    sub_cnt_next = sub_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    samples_next = samples_reg;
    vote_next    = vote_reg;
    restart      = 1'b0;
    push         = 1'b0;
    frame_evt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    parity_evt   = 1'b0;
`endif

    if (state_reg != IDLE && state_reg != BREAK && tick) begin
      sub_cnt_next = sub_cnt_reg + 4'd1;
      if (sub_cnt_reg == 4'd7) samples_next[0] = rx_sync;
      if (sub_cnt_reg == 4'd8) samples_next[1] = rx_sync;
      if (sub_cnt_reg == 4'd9) vote_next = vote_now;
    end

    case (state_reg)
      IDLE: begin
        if (fell) begin
          state_next   = START;
          restart      = 1'b1;
          sub_cnt_next = '0;
          bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_next = 1'b0;
`endif
        end
      end
      START: begin
        if (tick && sub_cnt_reg == 4'd15) begin
          state_next = vote_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && sub_cnt_reg == 4'd15) begin
          shift_next   = {vote_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Odd parity: data bits plus parity bit must hold an odd number of ones.
        if (tick && sub_cnt_reg == 4'd15) begin
          par_bad_next = ~(^shift_reg ^ vote_reg);
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && sub_cnt_reg == 4'd9) begin
          if (vote_now) begin
`ifdef UART_RX_PARITY_EN
            push       = !par_bad_reg;
            parity_evt = par_bad_reg;
`else
            push       = 1'b1;
`endif
            state_next = IDLE;
          end else begin
            frame_evt  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_sync) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .soc_clk (soc_clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (shift_reg),
    .pop     (rx_ready_i),
    .rdata   (rx_data_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_o)
  );

  assign rx_valid_o   = !fifo_empty;
  assign overflow_evt = push && fifo_full && !rx_ready_i;

  // A new error event in the same cycle as clear_i keeps the flag set.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (frame_evt)        frame_err_reg <= 1'b1;
      else if (clear_i)     frame_err_reg <= 1'b0;
      if (overflow_evt)     overflow_reg  <= 1'b1;
      else if (clear_i)     overflow_reg  <= 1'b0;
    end
  end

  assign frame_err_o = frame_err_reg;
  assign overflow_o  = overflow_reg;

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n)           parity_err_reg <= 1'b0;
    else if (parity_evt)  parity_err_reg <= 1'b1;
    else if (clear_i)     parity_err_reg <= 1'b0;
  end

  assign parity_err_o = parity_err_reg;
`endif

endmodule
